// File: rtl/if_of_pipe_reg.sv
// IF/OF pipeline register: two-entry skid buffer between fetch and operand fetch,
// with branch flush and a saturating count of consumer-ready bubble cycles.
module if_of_pipe_reg #(
    parameter int                     PC_WIDTH    = 32,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h68000000,
    parameter int                     CNT_WIDTH   = 16
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [PC_WIDTH-1:0]    In_PC,
    input  logic [INSTR_WIDTH-1:0] In_Instruction,
    input  logic                   Flush,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [PC_WIDTH-1:0]    Out_PC,
    output logic [INSTR_WIDTH-1:0] Out_Instruction,
    output logic [CNT_WIDTH-1:0]   Bubble_Count
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t                 state, state_n;
    logic                   in_ready_q;
    logic [PC_WIDTH-1:0]    main_pc, skid_pc;
    logic [INSTR_WIDTH-1:0] main_instr, skid_instr;
    logic [CNT_WIDTH-1:0]   bubble_q;
    logic                   accept, drain;
    logic                   ld_main_in, ld_main_skid, ld_skid;

    assign Out_Valid       = (state != EMPTY);
    assign In_Ready        = in_ready_q;
    assign accept          = In_Valid & in_ready_q;
    assign drain           = Out_Valid & Out_Ready;
    assign Out_PC          = Out_Valid ? main_pc : '0;
    assign Out_Instruction = Out_Valid ? main_instr : NOP_INSTR;
    assign Bubble_Count    = bubble_q;

    always_comb begin
        state_n      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (Flush) begin
            state_n = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    state_n    = ONE;
                    ld_main_in = 1'b1;
                end
                ONE: begin
                    if (accept && drain) begin
                        ld_main_in = 1'b1;
                    end else if (accept) begin
                        state_n = TWO;
                        ld_skid = 1'b1;
                    end else if (drain) begin
                        state_n = EMPTY;
                    end
                end
                TWO: if (drain) begin
                    state_n      = ONE;
                    ld_main_skid = 1'b1;
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_pc    <= '0;
            main_instr <= NOP_INSTR;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            state      <= state_n;
            // Ready is precomputed from the next state so it stays a pure flop output
            in_ready_q <= (state_n != TWO);
            if (ld_main_in) begin
                main_pc    <= In_PC;
                main_instr <= In_Instruction;
            end else if (ld_main_skid) begin
                main_pc    <= skid_pc;
                main_instr <= skid_instr;
            end
            if (ld_skid) begin
                skid_pc    <= In_PC;
                skid_instr <= In_Instruction;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bubble_q <= '0;
        end else if (Out_Ready && !Out_Valid && (bubble_q != '1)) begin
            bubble_q <= bubble_q + 1'b1;
        end
    end

endmodule

// File: doc/if_of_pipe_reg.md
IF_OF_PIPE_REG -- requirements
Module: if_of_pipe_reg

Interface
REQ-001: Parameter PC_WIDTH, default 32, width of program counter fields.
REQ-002: Parameter INSTR_WIDTH, default 32, width of instruction fields.
REQ-003: Parameter NOP_INSTR, default 32'h68000000 (SimpleRisc nop), instruction word presented when stage is empty.
REQ-004: Parameter CNT_WIDTH, default 16, width of bubble counter.
REQ-005: Clk  input  1  single clock; all state updates on rising edge.
REQ-006: Reset  input  1  asynchronous, active-high reset.
REQ-007: In_Valid  input  1  fetch stage presents a valid PC/instruction pair.
REQ-008: In_Ready  output  1  stage can accept a pair this cycle.
REQ-009: In_PC  input  PC_WIDTH  PC of incoming instruction.
REQ-010: In_Instruction  input  INSTR_WIDTH  incoming instruction word.
REQ-011: Flush  input  1  discard all held and incoming entries (branch taken).
REQ-012: Out_Valid  output  1  operand-fetch stage sees a valid pair.
REQ-013: Out_Ready  input  1  operand-fetch stage consumes pair this cycle.
REQ-014: Out_PC  output  PC_WIDTH  PC of presented instruction.
REQ-015: Out_Instruction  output  INSTR_WIDTH  presented instruction word.
REQ-016: Bubble_Count  output  CNT_WIDTH  count of cycles consumer was ready but stage empty.

Function
REQ-017: Stage SHALL be a two-entry skid buffer: Main register (presented) plus Skid register; states EMPTY, ONE, TWO.
REQ-018: accept = In_Valid & In_Ready; drain = Out_Valid & Out_Ready.
REQ-019: In_Ready SHALL be a registered output, 1 in EMPTY and ONE, 0 in TWO; no combinational path In_* or Out_Ready -> In_Ready.
REQ-020: Out_Valid SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-021: EMPTY: accept -> ONE, Main <= In pair; else stay.
REQ-022: ONE: accept & drain -> ONE, Main <= In; accept & !drain -> TWO, Skid <= In; !accept & drain -> EMPTY; neither -> hold.
REQ-023: TWO: drain -> ONE, Main <= Skid; else hold; no accept possible.
REQ-024: Pairs SHALL leave in arrival order; no pair dropped or duplicated except by Flush.
REQ-025: Latency: a pair accepted at edge N SHALL be presented with Out_Valid=1 from edge N+1 when stage was EMPTY.
REQ-026: Flush SHALL be synchronous and highest priority: next state EMPTY, same-cycle In pair discarded, same-cycle drain still counts as consumed by consumer, In_Ready=1 next cycle.
REQ-027: While Out_Valid=0, Out_Instruction SHALL equal NOP_INSTR and Out_PC SHALL equal 0.
REQ-028: Held data SHALL not change while Out_Valid=1 and Out_Ready=0.
REQ-029: Bubble_Count SHALL increment by 1 on each edge where Out_Ready=1 and Out_Valid=0, saturating at all-ones; Flush does not clear it.

Reset
REQ-030: Reset asserted SHALL immediately force state EMPTY, In_Ready=1, Out_Valid=0, Out_PC=0, Out_Instruction=NOP_INSTR, Skid contents=0, Bubble_Count=0, independent of Clk.
REQ-031: Reset mid-operation SHALL discard all held pairs; first accept after deassertion behaves as from EMPTY.

Verification
REQ-032: Reset, then In_Valid=1, In_PC=0x100, In_Instruction=0x12345678, Out_Ready=1 one cycle -> next cycle Out_Valid=1, Out_PC=0x100, Out_Instruction=0x12345678.
REQ-033: Out_Ready=0, push PC 0x4 then 0x8 -> state TWO, In_Ready=0, Out_PC=0x4; raise Out_Ready -> 0x4 then 0x8 presented, In_Ready=1 after first drain.
REQ-034: Stage in TWO, Flush=1 with In_Valid=1 -> next cycle Out_Valid=0, Out_Instruction=0x68000000, In_Ready=1, flushed pairs never reappear.
REQ-035: Continuous In_Valid=1, Out_Ready=1, PCs 0x0,0x4,...,0x3C -> 16 pairs out in order, one per cycle, Bubble_Count increments only on the first (empty) cycle.
REQ-036: Force Bubble_Count to 0xFFFE via 65534 empty ready cycles, run 3 more -> Bubble_Count=0xFFFF, stays; assert Reset asynchronously mid-cycle -> outputs reach reset values before next edge.
